// File: rtl/click_decoder_pkg.sv
// Shared types, default sizing and width helper for the click sequence decoder.
package click_decoder_pkg;

  typedef enum logic {
    IDLE,
    WINDOW
  } state_t;

  localparam int CLICK_WINDOW_DEF = 4096;
  localparam int MAX_CLICKS_DEF   = 3;

  // Width needed to hold a click count of 0..max_clicks.
  function automatic int cnt_width(input int max_clicks);
    return $clog2(max_clicks + 1);
  endfunction

endpackage

// File: rtl/click_window_timer.sv
// Silence timer for an open click burst: counts idle cycles and flags the last
// cycle of the window. Synchronous clear restarts the window.
module click_window_timer
  import click_decoder_pkg::*;
#(
  parameter int  CLICK_WINDOW = CLICK_WINDOW_DEF,
  localparam int TMR_W        = $clog2(CLICK_WINDOW)
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      timer <= '0;
    end else if (i_Clear) begin
      timer <= '0;
    end else if (i_Enable) begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign o_Terminal = (timer == TMR_W'(CLICK_WINDOW - 1));

endmodule

// File: rtl/click_sequence_decoder.sv
// Groups debounced release pulses into single/double/triple click bursts.
// Optional CLICK_DECODER_EARLY_EMIT_EN closes a burst as soon as it saturates.
module click_sequence_decoder
  import click_decoder_pkg::*;
#(
  parameter int  CLICK_WINDOW = CLICK_WINDOW_DEF,
  parameter int  MAX_CLICKS   = MAX_CLICKS_DEF,
  localparam int TMR_W        = $clog2(CLICK_WINDOW),
  localparam int CNT_W        = cnt_width(MAX_CLICKS)
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Released_Button,
  output logic             o_Click_Valid,
  output logic [CNT_W-1:0] o_Click_Count,
  output logic             o_Busy
);

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [CNT_W-1:0] count_inc;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] click_cnt_q, click_cnt_d;
  logic             tmr_clear;
  logic             tmr_enable;
  logic             tmr_done;
  logic             early_full;

  click_window_timer #(
    .CLICK_WINDOW(CLICK_WINDOW)
  ) u_timer (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Clear   (tmr_clear),
    .i_Enable  (tmr_enable),
    .o_Terminal(tmr_done)
  );

  assign tmr_enable = (state == WINDOW);
  assign count_inc  = (count >= CNT_W'(MAX_CLICKS)) ? count : count + CNT_W'(1);

`ifdef CLICK_DECODER_EARLY_EMIT_EN
  assign early_full = (count == CNT_W'(MAX_CLICKS));
`else
  assign early_full = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      count       <= '0;
      valid_q     <= 1'b0;
      click_cnt_q <= '0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      valid_q     <= valid_d;
      click_cnt_q <= click_cnt_d;
    end
  end

  // A pulse always takes priority over a timeout so no release is ever dropped;
  // a saturated burst (early-emit build) closes first and re-opens on a same-edge pulse.
  always_comb begin
    state_d     = state;
    count_d     = count;
    valid_d     = 1'b0;
    click_cnt_d = '0;
    tmr_clear   = 1'b0;
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (i_Released_Button) begin
          state_d = WINDOW;
          count_d = CNT_W'(1);
        end
      end
      WINDOW: begin
        if (early_full) begin
          valid_d     = 1'b1;
          click_cnt_d = count;
          tmr_clear   = 1'b1;
          if (i_Released_Button) begin
            count_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else if (i_Released_Button) begin
          count_d   = count_inc;
          tmr_clear = 1'b1;
        end else if (tmr_done) begin
          valid_d     = 1'b1;
          click_cnt_d = count;
          state_d     = IDLE;
          count_d     = '0;
          tmr_clear   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        tmr_clear = 1'b1;
      end
    endcase
  end

  assign o_Click_Valid = valid_q;
  assign o_Click_Count = click_cnt_q;
  assign o_Busy        = (state == WINDOW);

endmodule
